// File: rtl/uart_axis_arb_pkg.sv
// Shared types and sizing helpers for the UART AXI-Stream round-robin arbiter.
package uart_axis_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Counter must be able to hold the value MAX_BURST itself.
   function automatic int burst_cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/uart_axis_rr_arbiter_rr_pick.sv
// Rotating-priority scan: first asserted request at or after ptr, wrapping modulo N_REQ.
module rr_pick
   import uart_axis_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
      int sum;
      sum = int'(base) + offs;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return IDX_W'(sum);
   endfunction

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[wrap_add(ptr, k)]) begin
            idx   = wrap_add(ptr, k);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_axis_rr_arbiter.sv
// Round-robin arbiter sharing one registered AXI-Stream byte output (UART TX)
// between N_REQ sources, holding each grant for at most MAX_BURST beats.
module uart_axis_rr_arbiter
   import uart_axis_arb_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int AXI_DATA_WIDTH = 8,
   parameter int MAX_BURST      = 4
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [N_REQ*AXI_DATA_WIDTH-1:0]   s_tdata,
   input  logic [N_REQ-1:0]                  s_tvalid,
   output logic [N_REQ-1:0]                  s_tready,
   output logic [AXI_DATA_WIDTH-1:0]         m_tdata,
   output logic                              m_tvalid,
   input  logic                              m_tready,
   output logic [N_REQ-1:0]                  grant,
   output logic                              busy
);

   localparam int                IDX_W     = $clog2(N_REQ);
   localparam int                CNT_W     = burst_cnt_w(MAX_BURST);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

   state_t                    r_state;
   state_t                    w_next_state;
   logic [IDX_W-1:0]          r_gnt_idx;
   logic [IDX_W-1:0]          r_ptr;
   logic [CNT_W-1:0]          r_beat_cnt;
   logic [AXI_DATA_WIDTH-1:0] r_m_tdata;
   logic                      r_m_tvalid;

   logic [IDX_W-1:0]          w_pick_idx;
   logic                      w_pick_found;
   logic [IDX_W-1:0]          w_next_ptr;
   logic [N_REQ-1:0]          w_gnt_onehot;
   logic [AXI_DATA_WIDTH-1:0] w_sel_data;
   logic                      w_src_valid;
   logic                      w_slot_ready;
   logic                      w_xfer;
   logic                      w_exit;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (s_tvalid),
      .ptr   (r_ptr),
      .idx   (w_pick_idx),
      .found (w_pick_found)
   );

   assign w_gnt_onehot = N_REQ'(1) << r_gnt_idx;
   assign w_src_valid  = s_tvalid[r_gnt_idx];
   assign w_sel_data   = s_tdata[r_gnt_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
   // The output register can accept a byte when empty or draining this cycle.
   assign w_slot_ready = !r_m_tvalid || m_tready;
   assign w_next_ptr   = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + 1'b1;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_xfer       = 1'b0;
      w_exit       = 1'b0;
      s_tready     = '0;
      grant        = '0;
      case (r_state)
         IDLE: begin
            if (w_pick_found) w_next_state = GRANT;
         end
         GRANT: begin
            grant = w_gnt_onehot;
            if (w_slot_ready) s_tready = w_gnt_onehot;
            w_xfer = w_src_valid && w_slot_ready;
            // A stalled but valid source keeps the grant; an idle one releases it.
            if (!w_src_valid || (w_xfer && (r_beat_cnt == LAST_BEAT))) begin
               w_exit       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_gnt_idx  <= '0;
         r_ptr      <= '0;
         r_beat_cnt <= '0;
      end else begin
         if (r_state == IDLE && w_pick_found) begin
            r_gnt_idx  <= w_pick_idx;
            r_beat_cnt <= '0;
         end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
         if (w_exit) r_ptr <= w_next_ptr;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_m_tdata  <= '0;
         r_m_tvalid <= 1'b0;
      end else if (w_xfer) begin
         r_m_tdata  <= w_sel_data;
         r_m_tvalid <= 1'b1;
      end else if (m_tready) begin
         r_m_tvalid <= 1'b0;
      end
   end

   assign m_tdata  = r_m_tdata;
   assign m_tvalid = r_m_tvalid;
   assign busy     = (r_state == GRANT) || r_m_tvalid;

endmodule

// File: tb/tb_uart_axis_rr_arbiter.sv
// Bench: queue-driven sources, transaction-level round-robin burst model, directed and random phases.
module tb_uart_axis_rr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic          aclk;
   logic          areset;
   logic [N*W-1:0] s_tdata;
   logic [N-1:0]  s_tvalid;
   logic [N-1:0]  s_tready;
   logic [W-1:0]  m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic [N-1:0]  grant;
   logic          busy;

   uart_axis_rr_arbiter #(
      .N_REQ          (N),
      .AXI_DATA_WIDTH (W),
      .MAX_BURST      (MB)
   ) dut (
      .aclk     (aclk),
      .areset   (areset),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .grant    (grant),
      .busy     (busy)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q   [N][$];
   logic [7:0] lq  [N][$];
   logic [7:0] exp_q[$];
   int         exp_gnt[$];
   logic [7:0] out_log[$];
   logic [N-1:0] gnt_log[$];
   logic       mv_log[$];
   logic       sv_log[$];
   int         runs[$];
   int         mptr;
   bit         hold;
   bit         rnd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         s_tvalid[i]       = (q[i].size() != 0);
         s_tdata[i*W +: W] = (q[i].size() != 0) ? q[i][0] : 8'h00;
      end
      if (hold)     m_tready = 1'b0;
      else if (rnd) m_tready = ($urandom_range(0, 3) != 0);
      else          m_tready = 1'b1;
   endtask

   // One clock: commit handshakes seen before the edge, drive new inputs, then check invariants.
   task automatic step();
      logic [N-1:0] pop;
      logic         fire;
      logic         stall;
      logic [7:0]   oval;
      pop   = s_tvalid & s_tready;
      fire  = m_tvalid && m_tready;
      stall = m_tvalid && !m_tready;
      oval  = m_tdata;
      @(posedge aclk);
      #1;
      if (fire) out_log.push_back(oval);
      for (int i = 0; i < N; i++) if (pop[i]) q[i].delete(0);
      drive();
      #1;
      if (stall) begin
         check("stall_valid", 32'(m_tvalid), 32'd1);
         check("stall_data", 32'(m_tdata), 32'(oval));
      end
      check("tready_onehot0", 32'(s_tready & (s_tready - 4'd1)), 32'd0);
      check("tready_in_grant", 32'(s_tready & ~grant), 32'd0);
      check("grant_onehot0", 32'(grant & (grant - 4'd1)), 32'd0);
      check("busy", 32'(busy), 32'((grant != 0) || m_tvalid));
      gnt_log.push_back(grant);
      mv_log.push_back(m_tvalid);
      sv_log.push_back(|s_tvalid);
   endtask

   // Expected byte order: from ptr pick first non-empty source, take up to MB bytes, advance ptr.
   task automatic build_exp();
      int idx;
      int n;
      exp_q.delete();
      exp_gnt.delete();
      for (int i = 0; i < N; i++) lq[i] = q[i];
      for (int guard = 0; guard < 1000; guard++) begin
         idx = -1;
         for (int k = 0; k < N; k++)
            if (idx < 0 && lq[(mptr + k) % N].size() > 0) idx = (mptr + k) % N;
         if (idx < 0) break;
         n = (lq[idx].size() < MB) ? lq[idx].size() : MB;
         for (int j = 0; j < n; j++) begin
            exp_q.push_back(lq[idx][0]);
            lq[idx].delete(0);
         end
         exp_gnt.push_back(idx);
         mptr = (idx + 1) % N;
      end
   endtask

   task automatic begin_batch();
      build_exp();
      out_log.delete();
      gnt_log.delete();
      mv_log.delete();
      sv_log.delete();
   endtask

   task automatic get_runs();
      logic [N-1:0] prev;
      runs.delete();
      prev = '0;
      foreach (gnt_log[i]) begin
         if (gnt_log[i] != 0 && prev == 0)
            for (int k = 0; k < N; k++) if (gnt_log[i][k]) runs.push_back(k);
         prev = gnt_log[i];
      end
   endtask

   task automatic finish_batch(input string name);
      int n;
      n = 0;
      while (out_log.size() < exp_q.size() && n < 2000) begin
         step();
         n++;
      end
      repeat (4) step();
      check({name, "_beats"}, 32'(out_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
         check({name, "_data"}, 32'(out_log[i]), 32'(exp_q[i]));
      get_runs();
      check({name, "_bursts"}, 32'(runs.size()), 32'(exp_gnt.size()));
      for (int i = 0; i < exp_gnt.size() && i < runs.size(); i++)
         check({name, "_grant_order"}, 32'(runs[i]), 32'(exp_gnt[i]));
      check({name, "_end_grant"}, 32'(grant), 32'd0);
      check({name, "_end_mvalid"}, 32'(m_tvalid), 32'd0);
   endtask

   task automatic do_reset();
      areset = 1'b1;
      for (int i = 0; i < N; i++) q[i].delete();
      hold = 1'b0;
      drive();
      @(posedge aclk);
      #1;
      areset = 1'b0;
      mptr   = 0;
      #1;
   endtask

   task automatic load(input int src, input int n, input bit random_data);
      for (int j = 0; j < n; j++)
         q[src].push_back(random_data ? 8'((src << 6) | $urandom_range(0, 63))
                                      : 8'((src << 6) | (j & 63)));
   endtask

   initial begin
      int fs;
      int fm;
      int s;
      areset   = 1'b0;
      s_tdata  = '0;
      s_tvalid = '0;
      m_tready = 1'b0;
      hold     = 1'b0;
      rnd      = 1'b0;
      mptr     = 0;
      #2;
      areset = 1'b1;
      #1;
      check("rst_mvalid", 32'(m_tvalid), 32'd0);
      check("rst_mdata", 32'(m_tdata), 32'd0);
      check("rst_tready", 32'(s_tready), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      #1;
      drive();
      #1;
      check("idle_grant", 32'(grant), 32'd0);

      // Single source, latency and order
      q[0].push_back(8'h11);
      q[0].push_back(8'h22);
      q[0].push_back(8'h33);
      begin_batch();
      finish_batch("single");
      fs = -1;
      fm = -1;
      foreach (sv_log[i]) if (fs < 0 && sv_log[i]) fs = i;
      foreach (mv_log[i]) if (fm < 0 && mv_log[i]) fm = i;
      check("single_latency", 32'(fm - fs), 32'd2);
      check("single_grant", 32'(gnt_log[fs + 1]), 32'h1);

      // Full contention: 4-cycle bursts in order 0..3 with one idle cycle between
      do_reset();
      for (int i = 0; i < N; i++) load(i, 2 * MB, 1'b0);
      begin_batch();
      finish_batch("contend");
      s = -1;
      foreach (gnt_log[i]) if (s < 0 && gnt_log[i] != 0) s = i;
      for (int b = 0; b < 2 * N; b++) begin
         for (int j = 0; j < MB; j++)
            check("contend_run", 32'(gnt_log[s + b*(MB+1) + j]), 32'(1 << (b % N)));
         if (b < 2 * N - 1)
            check("contend_bubble", 32'(gnt_log[s + b*(MB+1) + MB]), 32'd0);
      end

      // Backpressure mid-burst
      do_reset();
      load(1, 6, 1'b1);
      begin_batch();
      repeat (4) step();
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_tready", 32'(s_tready), 32'd0);
         check("bp_mvalid", 32'(m_tvalid), 32'd1);
      end
      hold = 1'b0;
      finish_batch("bp");

      // Early release: source 2 has two beats while source 3 waits
      do_reset();
      load(2, 2, 1'b1);
      load(3, 3, 1'b1);
      begin_batch();
      finish_batch("early");
      check("early_first", 32'(runs[0]), 32'd2);
      check("early_next", 32'(runs[1]), 32'd3);

      // Priority wrap: move ptr to 2, then sources 1 and 3 compete
      load(1, 1, 1'b1);
      begin_batch();
      finish_batch("wrap_setup");
      load(1, 2, 1'b1);
      load(3, 2, 1'b1);
      begin_batch();
      finish_batch("wrap");
      check("wrap_first", 32'(runs[0]), 32'd3);
      check("wrap_second", 32'(runs[1]), 32'd1);

      // Reset mid-burst with a byte in the output register
      do_reset();
      for (int i = 0; i < N; i++) load(i, 8, 1'b1);
      begin_batch();
      repeat (5) step();
      check("midrst_pre_mvalid", 32'(m_tvalid), 32'd1);
      areset = 1'b1;
      #1;
      check("midrst_mvalid", 32'(m_tvalid), 32'd0);
      check("midrst_mdata", 32'(m_tdata), 32'd0);
      check("midrst_tready", 32'(s_tready), 32'd0);
      check("midrst_grant", 32'(grant), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      mptr   = 0;
      #1;
      begin_batch();
      finish_batch("postrst");
      check("postrst_first", 32'(runs[0]), 32'd0);

      // Random loads with random downstream backpressure
      rnd = 1'b1;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) load(i, $urandom_range(0, 9), 1'b1);
         begin_batch();
         finish_batch("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
